// File: rtl/vector_lane_sequencer.sv
// Vector instruction sequencer: stalls Fetch/Decode while it walks the
// active lanes, one ALU issue per cycle or one strided memory request per lane.
module vector_lane_sequencer #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 32,
   parameter int LW     = $clog2(LANES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_mem,
   input  logic              mem_write,
   input  logic [LW:0]       vlen,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic              mem_ready,
   input  logic              flush,
   output logic              stall,
   output logic              busy,
   output logic              lane_valid,
   output logic [LW-1:0]     lane_idx,
   output logic              lane_we,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE, S_ISSUE, S_MEM, S_DONE
   } state_e;

   localparam logic [LW:0] LANES_V = (LW+1)'(LANES);

   state_e              state_q, state_d;
   logic [LW:0]         idx_q, idx_d;
   logic [LW:0]         n_q, n_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic                op_mem_q, op_mem_d;
   logic                op_wr_q, op_wr_d;
   logic [LW:0]         vlen_c;
   logic                last;

   assign vlen_c = (vlen > LANES_V) ? LANES_V : vlen;
   assign last   = (idx_q == n_q - (LW+1)'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         n_q      <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         op_mem_q <= 1'b0;
         op_wr_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         n_q      <= n_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         op_mem_q <= op_mem_d;
         op_wr_q  <= op_wr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      n_d      = n_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      op_mem_d = op_mem_q;
      op_wr_d  = op_wr_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               n_d      = vlen_c;
               idx_d    = '0;
               addr_d   = base_addr;
               stride_d = stride;
               op_mem_d = is_mem;
               op_wr_d  = mem_write;
               if (vlen_c == '0)
                  state_d = S_DONE;
               else if (is_mem)
                  state_d = S_MEM;
               else
                  state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + (LW+1)'(1);
               if (last) state_d = S_DONE;
            end
         end
         S_MEM: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (mem_ready) begin
               idx_d  = idx_q + (LW+1)'(1);
               // address wraps modulo 2^ADDR_W
               addr_d = addr_q + stride_q;
               if (last) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall      = 1'b0;
      busy       = 1'b0;
      lane_valid = 1'b0;
      lane_idx   = '0;
      lane_we    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall = start & ~flush;
         end
         S_ISSUE: begin
            stall      = 1'b1;
            busy       = 1'b1;
            lane_idx   = idx_q[LW-1:0];
            lane_valid = ~flush & ~op_mem_q;
            lane_we    = ~flush & ~op_mem_q;
         end
         S_MEM: begin
            stall    = 1'b1;
            busy     = 1'b1;
            lane_idx = idx_q[LW-1:0];
            mem_req  = ~flush & op_mem_q;
            mem_we   = op_wr_q;
            mem_addr = addr_q;
            // load data is combinational, so write back on acceptance
            lane_we  = ~flush & op_mem_q & mem_ready & ~op_wr_q;
         end
         default: begin
            busy = 1'b1;
            done = ~flush;
         end
      endcase
   end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Scoreboard bench for vector_lane_sequencer: a reference model queues the
// expected lane/memory/done events and a monitor matches DUT activity.
module tb_vector_lane_sequencer;

   localparam int LANES = 4;
   localparam int AW    = 32;
   localparam int LW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          is_mem = 1'b0;
   logic          mem_write = 1'b0;
   logic [LW:0]   vlen = '0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] stride = '0;
   logic          mem_ready = 1'b0;
   logic          flush = 1'b0;
   logic          stall, busy, lane_valid, lane_we;
   logic          mem_req, mem_we, done;
   logic [LW-1:0] lane_idx;
   logic [AW-1:0] mem_addr;

   vector_lane_sequencer #(.LANES(LANES), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .is_mem(is_mem),
      .mem_write(mem_write), .vlen(vlen), .base_addr(base_addr),
      .stride(stride), .mem_ready(mem_ready), .flush(flush),
      .stall(stall), .busy(busy), .lane_valid(lane_valid),
      .lane_idx(lane_idx), .lane_we(lane_we), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            kind;
      int            idx;
      logic [AW-1:0] addr;
      logic          we;
   } ev_t;

   ev_t sb[$];
   int  total = 0;
   int  bad = 0;
   int  ready_mode = 1;
   bit  waited = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ready modes: 0 random, 1 high, 2 low on first cycle of each lane, 3 low
   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0: mem_ready = 1'($urandom_range(0, 1));
         1: mem_ready = 1'b1;
         2: mem_ready = waited;
         default: mem_ready = 1'b0;
      endcase
   end

   always @(negedge clk)
      if (ready_mode == 2 && mem_req) waited = !mem_ready;

   always @(negedge clk) begin
      ev_t e;
      if (rst && (lane_valid || mem_req || done || lane_we)) begin
         if (sb.size() == 0) begin
            chk("spurious", {60'd0, lane_valid, mem_req, done, lane_we}, 0);
         end else begin
            e = sb[0];
            if (lane_valid) begin
               chk("alu_kind", e.kind, 0);
               chk("alu_idx", lane_idx, e.idx);
               chk("alu_we_req", {lane_we, mem_req}, 2'b10);
               void'(sb.pop_front());
            end else if (mem_req) begin
               chk("mem_kind", e.kind, 1);
               chk("mem_idx", lane_idx, e.idx);
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_we", mem_we, e.we);
               chk("load_we", lane_we, mem_ready && !e.we);
               if (mem_ready) void'(sb.pop_front());
            end else if (done) begin
               chk("done_kind", e.kind, 2);
               void'(sb.pop_front());
            end else begin
               chk("stray_we", lane_we, 0);
            end
         end
      end
   end

   task automatic expect_op(input bit m, input bit w, input int vl,
                            input logic [AW-1:0] b, input logic [AW-1:0] s);
      int  n;
      ev_t e;
      n = (vl > LANES) ? LANES : vl;
      for (int i = 0; i < n; i++) begin
         e.kind = m ? 1 : 0;
         e.idx  = i;
         e.addr = b + AW'(i) * s;
         e.we   = w;
         sb.push_back(e);
      end
      e.kind = 2;
      e.idx  = 0;
      e.addr = '0;
      e.we   = 1'b0;
      sb.push_back(e);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
   task automatic run_op(input bit m, input bit w, input int vl,
                         input logic [AW-1:0] b, input logic [AW-1:0] s,
                         input int exp_done, input int exp_stall);
      int cyc;
      int stalls;
      bit got;
      expect_op(m, w, vl, b, s);
      start     = 1'b1;
      is_mem    = m;
      mem_write = w;
      vlen      = (LW+1)'(vl);
      base_addr = b;
      stride    = s;
      @(negedge clk);
      chk("start_busy_stall", {busy, stall}, 2'b01);
      stalls = 1;
      cyc    = 0;
      got    = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1'b1;
         else if (stall) stalls++;
      end
      if (!got) begin
         chk("done_timeout", 1, 0);
      end else begin
         chk("done_nostall", stall, 0);
         if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
         if (exp_stall >= 0) chk("stall_cycles", stalls, exp_stall);
      end
      @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int n;
      bit m;
      bit w;
      int vl;
      #3;
      chk("reset_outputs", {stall, busy, lane_valid, lane_idx, lane_we,
                            mem_req, mem_we, mem_addr, done}, 0);
      #9 rst = 1'b1;
      @(posedge clk);
      #1;

      ready_mode = 1;
      run_op(0, 0, 4, 0, 0, 5, 5);
      ready_mode = 2;
      waited = 1'b0;
      run_op(1, 0, 3, 32'h100, 32'h4, 7, 7);
      ready_mode = 1;
      run_op(1, 1, 2, 32'hFFFF_FFFC, 32'h8, 3, 3);
      run_op(0, 0, 0, 0, 0, 1, 1);
      run_op(1, 0, 0, 32'h40, 32'h4, 1, 1);
      run_op(0, 0, 7, 0, 0, 5, 5);
      run_op(1, 0, 7, 32'h1000, 32'h10, 5, 5);

      // flush on lane 2 of a four-lane arithmetic op
      expect_op(0, 0, 2, 0, 0);
      void'(sb.pop_back());
      start  = 1'b1;
      is_mem = 1'b0;
      vlen   = 3'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_gate", {lane_valid, lane_we, mem_req, done}, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_sb", sb.size(), 0);
      run_op(0, 0, 2, 0, 0, 3, 3);

      // reset while a memory request is pending
      ready_mode = 3;
      expect_op(1, 0, 3, 32'h200, 32'h4);
      start     = 1'b1;
      is_mem    = 1'b1;
      mem_write = 1'b0;
      vlen      = 3'd3;
      base_addr = 32'h200;
      stride    = 32'h4;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("mem_pending", {mem_req, busy}, 2'b11);
      #2 rst = 1'b0;
      #1;
      chk("rst_outputs", {stall, busy, lane_valid, lane_idx, lane_we,
                          mem_req, mem_we, mem_addr, done}, 0);
      sb.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {busy, stall, done, mem_req}, 0);
      @(posedge clk);
      #1;

      for (int t = 0; t < 40; t++) begin
         m  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         vl = $urandom_range(0, 7);
         n  = (vl > LANES) ? LANES : vl;
         ready_mode = $urandom_range(0, 1);
         if (!m || ready_mode == 1)
            run_op(m, w, vl, $urandom, $urandom, n + 1, n + 1);
         else
            run_op(m, w, vl, $urandom, $urandom, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vector_lane_sequencer.md
# vector_lane_sequencer

Multi-cycle sequencer for vector instructions (opcode 001 vector arithmetic, 101 vector memory) in the pipelined processor. While a vector instruction sits in Decode, the block stalls Fetch/Decode and walks the active lanes one element per step. Arithmetic lanes are issued one per cycle to the shared lane ALU. Memory lanes are issued as strided requests to data memory with a ready handshake. It pulses `done` when the instruction may leave Decode.

## Interface
- `LANES`, default 4: number of vector elements; power of two, ≥2.
- `ADDR_W`, default 32: data-memory address width.
- `LW`, default $clog2(LANES): lane index width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: a vector instruction (opcode 001 or 101) is valid in Decode.
- `is_mem` in 1: 1 = vector memory access (101), 0 = vector arithmetic (001); sampled with `start`.
- `mem_write` in 1: for memory ops, 1 = store, 0 = load; sampled with `start`.
- `vlen` in LW+1: active element count; values above LANES clamp to LANES; sampled with `start`.
- `base_addr` in ADDR_W: address of element 0; sampled with `start`.
- `stride` in ADDR_W: byte distance between elements; sampled with `start`.
- `mem_ready` in 1: memory accepts the current request this cycle.
- `flush` in 1: synchronous abort, driven by a taken branch or pipeline flush.
- `stall` out 1: hold Fetch and Decode.
- `busy` out 1: state is not IDLE.
- `lane_valid` out 1: lane ALU operation issued this cycle.
- `lane_idx` out LW: element being processed.
- `lane_we` out 1: write the lane result into vector register element `lane_idx`.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: request is a store.
- `mem_addr` out ADDR_W: request address.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, MEM, DONE. Registered `idx` (LW+1 bits), `n` (clamped vlen), `addr` (ADDR_W), `op_mem`, `op_wr`.
- IDLE:
  - If `start & ~flush`, latch all operands, set idx=0 and addr=base_addr.
  - Next state is DONE if n==0, MEM if is_mem, else ISSUE.
- ISSUE:
  - Each cycle: lane_valid=1, lane_we=1, lane_idx=idx; then idx++.
  - When idx==n-1, go to DONE.
- MEM:
  - mem_req=1, mem_we=op_wr, mem_addr=addr, lane_idx=idx; all held stable until accepted.
  - On `mem_ready`: idx++, addr += stride (modulo 2^ADDR_W, wraps silently). For a load, lane_we=1 in the same cycle; memory read data is combinational. When idx==n-1, go to DONE.
  - Without `mem_ready`: hold, no lane_we.
- DONE: done=1 for one cycle, then IDLE. `start` is ignored here: the same instruction is still in Decode and leaves at the end of this cycle.
- `stall` = (IDLE & start & ~flush) | ISSUE | MEM. `stall` is low in DONE.
- `busy` = state != IDLE.
- `flush` in any non-IDLE state:
  - Next state IDLE; no `done`.
  - In the flush cycle, lane_we, lane_valid and mem_req are forced 0.
- `start` while busy is ignored.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, idx=0, addr=0, n=0, op_mem=0, op_wr=0. All outputs 0 (stall, busy, lane_valid, lane_idx, lane_we, mem_req, mem_we, mem_addr, done).
- Reset asserted mid-operation: abort immediately, no done pulse, no further writes.
- Arithmetic op with n lanes:
  - `start` at cycle 0, with stall=1 in that cycle.
  - Lanes issued at cycles 1..n.
  - done at cycle n+1; IDLE at cycle n+2.
  - Total stall = n+1 cycles.
- Memory op: the same pattern, except each lane occupies 1 + (wait cycles until mem_ready) cycles. With mem_ready tied high it matches the arithmetic timing.
- n==0: stall at cycle 0, done at cycle 1, no lane activity.
- Outputs are combinational from state/registers only, except the start-cycle stall term and the flush gating.

## Test plan
- Arithmetic, vlen=4, LANES=4 → lane_valid/lane_we high at cycles 1-4 with lane_idx 0,1,2,3; done at cycle 5; stall high for cycles 0-4 exactly.
- Load, vlen=3, base=0x100, stride=4, mem_ready low in the first cycle of each lane → addresses 0x100, 0x104, 0x108 each held for 2 cycles; lane_we only on ready cycles; done after 6 lane cycles.
- Store, vlen=2, base=0xFFFF_FFFC, stride=8 → mem_we=1; addresses 0xFFFF_FFFC, then 0x0000_0004 (wrap); lane_we never asserted.
- vlen=0, then separately vlen=7 with LANES=4 → first: done at cycle 1, no lane_valid or mem_req; second: clamped to exactly 4 lanes.
- Flush at lane 2 of a 4-lane arithmetic op → no lane_we in the flush cycle; IDLE next cycle; no done. A new `start` is accepted the following cycle.
- `rst` pulled low during MEM with mem_req=1 → all outputs 0 immediately; after release, IDLE with no done and no stall.
